// File: rtl/wb_switch_nslave.sv
// Single-master Wishbone switch: decodes a slave index from an address field and
// routes one registered transaction at a time, with unmapped/timeout error capture.
module wb_switch_nslave #(
    parameter int unsigned NUM_SLAVES = 7,
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned SEL_LSB    = 8,
    parameter int unsigned SEL_W      = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       m_stb_i,
    input  logic                       m_we_i,
    input  logic [AW-1:0]              m_adr_i,
    input  logic [DW-1:0]              m_dat_i,
    input  logic [DW/8-1:0]            m_sel_i,
    output logic [DW-1:0]              m_dat_o,
    output logic                       m_ack_o,
    output logic                       m_err_o,
    output logic [NUM_SLAVES-1:0]      s_cyc_o,
    output logic [NUM_SLAVES-1:0]      s_stb_o,
    output logic                       s_we_o,
    output logic [AW-1:0]              s_adr_o,
    output logic [DW-1:0]              s_dat_o,
    output logic [DW/8-1:0]            s_sel_o,
    input  logic [NUM_SLAVES*DW-1:0]   s_dat_i,
    input  logic [NUM_SLAVES-1:0]      s_ack_i,
    output logic [AW-1:0]              err_adr_o,
    output logic [1:0]                 err_code_o
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] CODE_UNMAPPED = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [SEL_W-1:0]        idx_q, idx_d;
    logic [NUM_SLAVES-1:0]   cyc_d;
    logic                    we_d;
    logic [AW-1:0]           adr_d;
    logic [DW-1:0]           wdat_d;
    logic [SW-1:0]           sel_d;
    logic [DW-1:0]           rdat_d;
    logic                    ack_d;
    logic                    err_d;
    logic [AW-1:0]           eadr_d;
    logic [1:0]              ecode_d;

    logic [SEL_W-1:0]        adr_idx;
    logic                    adr_mapped;
    logic [NUM_SLAVES-1:0]   adr_onehot;
    logic                    sel_ack;
    logic [DW-1:0]           sel_dat;

    assign adr_idx    = m_adr_i[SEL_LSB +: SEL_W];
    assign adr_mapped = ({1'b0, adr_idx} < (SEL_W + 1)'(NUM_SLAVES));
    assign s_stb_o    = s_cyc_o;

    // Slave decode for the incoming address and return mux for the latched index
    always_comb begin
        sel_ack    = 1'b0;
        sel_dat    = '0;
        adr_onehot = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (idx_q == SEL_W'(k)) begin
                sel_ack = s_ack_i[k];
                sel_dat = s_dat_i[k*DW +: DW];
            end
            adr_onehot[k] = (adr_idx == SEL_W'(k));
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        cyc_d   = s_cyc_o;
        we_d    = s_we_o;
        adr_d   = s_adr_o;
        wdat_d  = s_dat_o;
        sel_d   = s_sel_o;
        rdat_d  = m_dat_o;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        eadr_d  = err_adr_o;
        ecode_d = err_code_o;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (m_stb_i) begin
                    we_d   = m_we_i;
                    adr_d  = m_adr_i;
                    wdat_d = m_dat_i;
                    sel_d  = m_sel_i;
                    idx_d  = adr_idx;
                    if (adr_mapped) begin
                        cyc_d   = adr_onehot;
                        state_d = BUSY;
                    end else begin
                        err_d   = 1'b1;
                        eadr_d  = m_adr_i;
                        ecode_d = CODE_UNMAPPED;
                        state_d = ERR;
                    end
                end
            end
            BUSY: begin
                // A selected ack in the final timer cycle still completes normally
                if (sel_ack) begin
                    if (!s_we_o) begin
                        rdat_d = sel_dat;
                    end
                    cyc_d   = '0;
                    ack_d   = 1'b1;
                    state_d = RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    cyc_d   = '0;
                    err_d   = 1'b1;
                    eadr_d  = s_adr_o;
                    ecode_d = CODE_TIMEOUT;
                    state_d = ERR;
                end else if (timer_q != TW'(TIMEOUT)) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            idx_q      <= '0;
            s_cyc_o    <= '0;
            s_we_o     <= 1'b0;
            s_adr_o    <= '0;
            s_dat_o    <= '0;
            s_sel_o    <= '0;
            m_dat_o    <= '0;
            m_ack_o    <= 1'b0;
            m_err_o    <= 1'b0;
            err_adr_o  <= '0;
            err_code_o <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            s_cyc_o    <= cyc_d;
            s_we_o     <= we_d;
            s_adr_o    <= adr_d;
            s_dat_o    <= wdat_d;
            s_sel_o    <= sel_d;
            m_dat_o    <= rdat_d;
            m_ack_o    <= ack_d;
            m_err_o    <= err_d;
            err_adr_o  <= eadr_d;
            err_code_o <= ecode_d;
        end
    end

endmodule

// File: tb/tb_wb_switch_nslave.sv
// Directed bench for wb_switch_nslave: table of transactions with a simple slave
// responder, plus hand sequences for late ack and reset during a transaction.
module tb_wb_switch_nslave;

    localparam int unsigned NS = 7;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b0;
    logic                m_stb_i = 1'b0;
    logic                m_we_i = 1'b0;
    logic [AW-1:0]       m_adr_i = '0;
    logic [DW-1:0]       m_dat_i = '0;
    logic [DW/8-1:0]     m_sel_i = '0;
    logic [DW-1:0]       m_dat_o;
    logic                m_ack_o;
    logic                m_err_o;
    logic [NS-1:0]       s_cyc_o;
    logic [NS-1:0]       s_stb_o;
    logic                s_we_o;
    logic [AW-1:0]       s_adr_o;
    logic [DW-1:0]       s_dat_o;
    logic [DW/8-1:0]     s_sel_o;
    logic [NS*DW-1:0]    s_dat_i = '0;
    logic [NS-1:0]       s_ack_i = '0;
    logic [AW-1:0]       err_adr_o;
    logic [1:0]          err_code_o;

    int checks = 0;
    int errors = 0;

    wb_switch_nslave #(
        .NUM_SLAVES(NS), .AW(AW), .DW(DW), .SEL_LSB(8), .SEL_W(4), .TIMEOUT(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_sel_i(m_sel_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .err_adr_o(err_adr_o), .err_code_o(err_code_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          we;
        logic [31:0]   adr;
        logic [31:0]   dat;
        logic [3:0]    sel;
        int            ack_at;     // BUSY cycle (0-based) in which the selected slave acks
        logic [NS-1:0] noise;      // acks from non-selected slaves during BUSY
        logic [31:0]   rdat;       // data presented by the selected slave
        logic [NS-1:0] exp_stb;
        int            exp_edges;  // edges from sampling edge until ack/err visible
        int            exp_busy;   // cycles with a strobe asserted
        logic          exp_ack;
        logic          exp_err;
        logic [31:0]   exp_mdat;
        logic [1:0]    exp_code;
        logic [31:0]   exp_eadr;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int edges;
        int busy;
        logic done;
        logic [NS-1:0] stb_seen;
        @(negedge clk_i);
        m_stb_i = 1'b1;
        m_we_i  = v.we;
        m_adr_i = v.adr;
        m_dat_i = v.dat;
        m_sel_i = v.sel;
        for (int k = 0; k < int'(NS); k++) begin
            s_dat_i[k*DW +: DW] = 32'hC000_0000 | 32'(k);
            if (v.exp_stb[k]) s_dat_i[k*DW +: DW] = v.rdat;
        end
        edges = 0;
        busy = 0;
        done = 1'b0;
        stb_seen = '0;
        while (!done && edges < 20) begin
            @(posedge clk_i);
            #1;
            edges++;
            s_ack_i = '0;
            if (m_ack_o || m_err_o) begin
                done = 1'b1;
            end else if (s_stb_o != '0) begin
                stb_seen = stb_seen | s_stb_o;
                s_ack_i = v.noise | ((busy == v.ack_at) ? v.exp_stb : '0);
                busy++;
            end
        end
        chk($sformatf("v%0d edges", id), 64'(edges), 64'(v.exp_edges));
        chk($sformatf("v%0d busy", id), 64'(busy), 64'(v.exp_busy));
        chk($sformatf("v%0d stb", id), 64'(stb_seen), 64'(v.exp_stb));
        chk($sformatf("v%0d ack", id), 64'(m_ack_o), 64'(v.exp_ack));
        chk($sformatf("v%0d err", id), 64'(m_err_o), 64'(v.exp_err));
        chk($sformatf("v%0d mdat", id), 64'(m_dat_o), 64'(v.exp_mdat));
        chk($sformatf("v%0d code", id), 64'(err_code_o), 64'(v.exp_code));
        chk($sformatf("v%0d eadr", id), 64'(err_adr_o), 64'(v.exp_eadr));
        chk($sformatf("v%0d s_we", id), 64'(s_we_o), 64'(v.we));
        chk($sformatf("v%0d s_adr", id), 64'(s_adr_o), 64'(v.adr));
        chk($sformatf("v%0d s_dat", id), 64'(s_dat_o), 64'(v.dat));
        chk($sformatf("v%0d s_sel", id), 64'(s_sel_o), 64'(v.sel));
        @(negedge clk_i);
        m_stb_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk($sformatf("v%0d pulse", id), 64'({m_ack_o, m_err_o}), 64'(0));
        chk($sformatf("v%0d idle_stb", id), 64'(s_stb_o), 64'(0));
    endtask

    vec_t vecs[8];
    vec_t post_rst;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        int edges;

        //         we    adr            dat            sel      ack noise       rdat           stb          ed bz ack  err  mdat           code   eadr
        vecs[0] = '{1'b0, 32'h0000_0200, 32'h0,         4'hF,    0,  7'b0000000, 32'hDEAD_BEEF, 7'b0000100, 2, 1, 1'b1, 1'b0, 32'hDEAD_BEEF, 2'b00, 32'h0};
        vecs[1] = '{1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011, 0,  7'b0000000, 32'hFFFF_FFFF, 7'b0000010, 2, 1, 1'b1, 1'b0, 32'hDEAD_BEEF, 2'b00, 32'h0};
        vecs[2] = '{1'b0, 32'h0000_0900, 32'h0,         4'hF,    0,  7'b0000000, 32'h0,         7'b0000000, 1, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'b01, 32'h0000_0900};
        vecs[3] = '{1'b0, 32'h0000_0600, 32'h0,         4'hF,    2,  7'b0111111, 32'hCAFE_F00D, 7'b1000000, 4, 3, 1'b1, 1'b0, 32'hCAFE_F00D, 2'b01, 32'h0000_0900};
        vecs[4] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF,    99, 7'b1111110, 32'h1111_1111, 7'b0000001, 5, 4, 1'b0, 1'b1, 32'hCAFE_F00D, 2'b10, 32'h0000_0010};
        vecs[5] = '{1'b0, 32'hABCD_0300, 32'h0,         4'hF,    3,  7'b0000000, 32'h0BAD_CAFE, 7'b0001000, 5, 4, 1'b1, 1'b0, 32'h0BAD_CAFE, 2'b10, 32'h0000_0010};
        vecs[6] = '{1'b0, 32'h0000_0700, 32'h0,         4'hF,    0,  7'b0000000, 32'h0,         7'b0000000, 1, 0, 1'b0, 1'b1, 32'h0BAD_CAFE, 2'b01, 32'h0000_0700};
        vecs[7] = '{1'b0, 32'hFFFF_F1FF, 32'h0,         4'hF,    1,  7'b0000000, 32'h5A5A_A5A5, 7'b0000010, 3, 2, 1'b1, 1'b0, 32'h5A5A_A5A5, 2'b01, 32'h0000_0700};
        post_rst = '{1'b0, 32'h0000_0200, 32'h0,        4'hF,    0,  7'b0000000, 32'h600D_F00D, 7'b0000100, 2, 1, 1'b1, 1'b0, 32'h600D_F00D, 2'b00, 32'h0};

        // Reset state
        #12;
        chk("rst outputs", 64'({m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, err_code_o}), 64'(0));
        chk("rst data", 64'({m_dat_o, err_adr_o}), 64'(0));
        @(negedge clk_i);
        rst_i = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Timeout followed by a late ack from the abandoned slave
        held = m_dat_o;
        @(negedge clk_i);
        m_stb_i = 1'b1;
        m_we_i  = 1'b0;
        m_adr_i = 32'h0000_0400;
        edges = 0;
        while (!m_err_o && edges < 10) begin
            @(posedge clk_i);
            #1;
            edges++;
        end
        chk("late edges", 64'(edges), 64'(5));
        chk("late code", 64'(err_code_o), 64'(2'b10));
        chk("late eadr", 64'(err_adr_o), 64'(32'h0000_0400));
        s_ack_i = '1;
        @(negedge clk_i);
        m_stb_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("late ack1", 64'({m_ack_o, m_err_o}), 64'(0));
        @(posedge clk_i);
        #1;
        chk("late ack2", 64'({m_ack_o, m_err_o}), 64'(0));
        chk("late mdat", 64'(m_dat_o), 64'(held));
        s_ack_i = '0;

        // Reset asserted while a transaction is in BUSY
        @(negedge clk_i);
        m_stb_i = 1'b1;
        m_adr_i = 32'h0000_0300;
        @(posedge clk_i);
        #1;
        chk("mid stb", 64'(s_stb_o), 64'(7'b0001000));
        #3;
        rst_i = 1'b0;
        #1;
        chk("mid rst stb", 64'({s_cyc_o, s_stb_o}), 64'(0));
        chk("mid rst pulse", 64'({m_ack_o, m_err_o}), 64'(0));
        chk("mid rst code", 64'(err_code_o), 64'(0));
        chk("mid rst eadr", 64'(err_adr_o), 64'(0));
        chk("mid rst mdat", 64'(m_dat_o), 64'(0));
        m_stb_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;

        run_vec(8, post_rst);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
